commit_map: RTL and testbench

Architectural (committed) register map for the out-of-order MIPS core. Sits on the receiving end of the active list's retirement writeback stream (`issue_ifc`): each retiring instruction updates the logical→physical committed mapping, and the displaced physical register is queued back toward the free list. On a pipeline flush it replays the full committed map, one entry per cycle, so rename can restore its speculative table.

---
 rtl/mips_core_pkg.sv | 14 +
 rtl/commit_map_if.sv | 19 +
 rtl/commit_free_fifo.sv | 45 ++++
 rtl/commit_map.sv | 125 ++++++++++++
 tb/tb_commit_map.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: physical register handle, map size and commit-map FSM states.
package mips_core_pkg;

  localparam int PHYS_REG_BITS      = 6;
  localparam int COMMIT_MAP_ENTRIES = 32;

  typedef logic [PHYS_REG_BITS-1:0] MipsReg;

  typedef enum logic {
    IDLE,
    RESTORE
  } commit_map_state_t;

endpackage

// File: rtl/commit_map_if.sv
// Retirement writeback stream and hazard control bundles consumed by commit_map.
interface issue_ifc;
  import mips_core_pkg::*;

  logic       issue;
  logic [4:0] logical_address;
  MipsReg     physical_addr;

  modport in  (input  issue, logical_address, physical_addr);
  modport out (output issue, logical_address, physical_addr);
endinterface

interface hazard_control_ifc;
  logic stall;
  logic flush;

  modport in  (input  stall, flush);
  modport out (output stall, flush);
endinterface

// File: rtl/commit_free_fifo.sv
// Small FIFO of freed physical registers; pointers carry an extra wrap bit for full/empty.
module commit_free_fifo #(
  parameter int  DEPTH  = 4,
  parameter type elem_t = mips_core_pkg::MipsReg
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  elem_t push_data,
  input  logic  pop,
  output elem_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  elem_t       mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity and empty gates the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/commit_map.sv
// Committed logical->physical map: retires writebacks, frees displaced registers, replays on flush.
// Optional COMMIT_MAP_STATS_EN adds stat_commits / stat_frees counters.
module commit_map
  import mips_core_pkg::*;
#(
  parameter int FREE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  hazard_control_ifc.in i_hc,
  issue_ifc.in       i_wb,
  output logic       commit_ready,
  output logic       free_valid,
  output MipsReg     free_preg,
  input  logic       free_ready,
  output logic       restore_valid,
  output logic [4:0] restore_logical,
  output MipsReg     restore_physical,
  output logic       restore_busy
`ifdef COMMIT_MAP_STATS_EN
  ,
  output logic [31:0] stat_commits,
  output logic [31:0] stat_frees
`endif
);

  commit_map_state_t state, state_next;
  logic [4:0]        idx_next;
  MipsReg            map [COMMIT_MAP_ENTRIES];

  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   accept;
  logic   map_we;
  logic   push;
  logic   flush_take;
  MipsReg old_preg;

  assign pop        = free_valid && free_ready;
  assign flush_take = i_hc.flush && !i_hc.stall;
  assign old_preg   = map[i_wb.logical_address];

  // Flush wins over a same-cycle commit, so it is folded into commit_ready.
  assign commit_ready = rst_n && (state == IDLE) && !i_hc.stall && !i_hc.flush
                        && (!fifo_full || pop);
  assign accept = i_wb.issue && commit_ready;
  assign map_we = accept && (i_wb.logical_address != 5'd0);
  assign push   = map_we && (old_preg != i_wb.physical_addr);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = '0;
    case (state)
      IDLE: begin
        if (flush_take) state_next = RESTORE;
      end
      RESTORE: begin
        if (flush_take) begin
          idx_next = '0;
        end else if (restore_logical == 5'(COMMIT_MAP_ENTRIES - 1)) begin
          state_next = IDLE;
        end else begin
          idx_next = restore_logical + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      restore_valid    <= 1'b0;
      restore_busy     <= 1'b0;
      restore_logical  <= '0;
      restore_physical <= '0;
    end else begin
      state            <= state_next;
      restore_valid    <= (state_next == RESTORE);
      restore_busy     <= (state_next == RESTORE);
      restore_logical  <= (state_next == RESTORE) ? idx_next : '0;
      restore_physical <= (state_next == RESTORE) ? map[idx_next] : '0;
    end
  end

  // The map is architectural state: reset must restore the identity mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COMMIT_MAP_ENTRIES; i++) map[i] <= MipsReg'(i);
    end else if (map_we) begin
      map[i_wb.logical_address] <= i_wb.physical_addr;
    end
  end

  commit_free_fifo #(
    .DEPTH  (FREE_DEPTH),
    .elem_t (MipsReg)
  ) u_free_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (old_preg),
    .pop       (pop),
    .head      (free_preg),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign free_valid = !fifo_empty;

`ifdef COMMIT_MAP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commits <= '0;
      stat_frees   <= '0;
    end else begin
      if (accept) stat_commits <= stat_commits + 32'd1;
      if (pop)    stat_frees   <= stat_frees + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_map.sv
// Directed bench for commit_map: commits, free FIFO backpressure, flush replay, reset mid-replay.
module tb_commit_map;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_control_ifc hc ();
  issue_ifc          wb ();

  logic       commit_ready, free_valid, free_ready;
  logic       restore_valid, restore_busy;
  logic [4:0] restore_logical;
  MipsReg     free_preg, restore_physical;
`ifdef COMMIT_MAP_STATS_EN
  logic [31:0] stat_commits, stat_frees;
`endif

  commit_map #(.FREE_DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_hc             (hc),
    .i_wb             (wb),
    .commit_ready     (commit_ready),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .free_ready       (free_ready),
    .restore_valid    (restore_valid),
    .restore_logical  (restore_logical),
    .restore_physical (restore_physical),
    .restore_busy     (restore_busy)
`ifdef COMMIT_MAP_STATS_EN
    ,
    .stat_commits     (stat_commits),
    .stat_frees       (stat_frees)
`endif
  );

  int     n_vec = 0;
  int     n_bad = 0;
  MipsReg exp_map [32];
  MipsReg exp_q [$];
  int     exp_commits;
  int     exp_frees;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) exp_map[i] = MipsReg'(i);
    exp_q.delete();
    exp_commits = 0;
    exp_frees   = 0;
  endtask

  // Advance one clock; the model pops when the head is offered and accepted.
  task automatic tick();
    if (free_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_frees++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_free(input string tag);
    MipsReg head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, "_valid"}, free_valid, exp_q.size() > 0);
    check({tag, "_preg"}, free_preg, head);
  endtask

  task automatic commit(input int l, input int p, input bit exp_ready);
    wb.issue           = 1'b1;
    wb.logical_address = 5'(l);
    wb.physical_addr   = MipsReg'(p);
    #1 check($sformatf("commit_ready_l%0d", l), commit_ready, exp_ready);
    tick();
    wb.issue = 1'b0;
    if (exp_ready) begin
      exp_commits++;
      if (l != 0) begin
        if (exp_map[l] != MipsReg'(p)) exp_q.push_back(exp_map[l]);
        exp_map[l] = MipsReg'(p);
      end
    end
  endtask

  // Flush (with a commit that must be dropped), then walk the replay; optionally re-flush at restart_at.
  task automatic replay(input int restart_at);
    int seen;
    int idx;
    bit restarted;
    seen      = 0;
    idx       = 0;
    restarted = (restart_at < 0);
    hc.flush           = 1'b1;
    hc.stall           = 1'b0;
    wb.issue           = 1'b1;
    wb.logical_address = 5'd8;
    wb.physical_addr   = MipsReg'(30);
    #1 check("flush_commit_ready", commit_ready, 0);
    tick();
    hc.flush = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!restore_busy) break;
      check("rst_valid", restore_valid, 1);
      check("rst_logical", restore_logical, idx);
      check("rst_physical", restore_physical, exp_map[idx]);
      check("rst_commit_blocked", commit_ready, 0);
      seen++;
      if (!restarted && idx == restart_at) begin
        hc.flush  = 1'b1;
        hc.stall  = 1'b0;
        restarted = 1'b1;
        idx       = 0;
      end else begin
        hc.stall = ((c % 5) == 3);
        idx++;
      end
      tick();
      hc.flush = 1'b0;
    end
    wb.issue = 1'b0;
    hc.stall = 1'b0;
    check("replay_len", seen, (restart_at < 0) ? 32 : restart_at + 33);
    check("rst_valid_end", restore_valid, 0);
    check("rst_logical_end", restore_logical, 0);
    check("rst_physical_end", restore_physical, 0);
    #1 check("cr_after_replay", commit_ready, (exp_q.size() < 4) || (free_ready && exp_q.size() > 0));
  endtask

  initial begin
    hc.stall = 1'b0;
    hc.flush = 1'b0;
    wb.issue = 1'b0;
    wb.logical_address = '0;
    wb.physical_addr   = '0;
    free_ready = 1'b0;
    reset_model();

    #1;
    check("rst_commit_ready", commit_ready, 0);
    check("rst_free_valid", free_valid, 0);
    check("rst_free_preg", free_preg, 0);
    check("rst_restore_valid", restore_valid, 0);
    check("rst_restore_logical", restore_logical, 0);
    check("rst_restore_physical", restore_physical, 0);
    check("rst_restore_busy", restore_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("idle_commit_ready", commit_ready, 1);

    // Logical 3 -> phys 7 frees phys 3 one cycle later.
    free_ready = 1'b1;
    commit(3, 7, 1);
    check("t1_free_valid", free_valid, 1);
    check("t1_free_preg", free_preg, 3);
    check("t1_commit_ready", commit_ready, 1);
    tick();
    check_free("t1_drained");

    // Backpressure: four frees fill the FIFO, fifth commit waits for a pop.
    free_ready = 1'b0;
    commit(1, 20, 1);
    commit(2, 21, 1);
    commit(4, 22, 1);
    commit(6, 23, 1);
    check_free("t2_full_head");
    wb.issue           = 1'b1;
    wb.logical_address = 5'd7;
    wb.physical_addr   = MipsReg'(24);
    #1 check("t2_full_blocks", commit_ready, 0);
    free_ready = 1'b1;
    commit(7, 24, 1);
    check("t2_head_after_pop", free_preg, 2);
    for (int i = 0; i < 4; i++) begin
      check_free($sformatf("t2_drain%0d", i));
      tick();
    end
    check_free("t2_empty");

    // Logical 0 and same-mapping commits free nothing.
    commit(0, 9, 1);
    check_free("t3_l0");
    commit(5, 5, 1);
    check_free("t3_same");

    // Flush while stalled is ignored.
    hc.stall = 1'b1;
    hc.flush = 1'b1;
    #1 check("stall_commit_ready", commit_ready, 0);
    tick();
    hc.stall = 1'b0;
    hc.flush = 1'b0;
    check("stall_flush_ignored", restore_valid, 0);
    #1 check("stall_release_cr", commit_ready, 1);

    // Commit 2 -> 12 keeps phys 21 queued across two replays.
    free_ready = 1'b0;
    commit(2, 12, 1);
    check("t4_free_preg", free_preg, 21);
    replay(-1);
    check_free("t4_held");
    replay(10);
    check_free("t5_held");
    free_ready = 1'b1;
    tick();
    check_free("t5_drained");

    // Reset in the middle of a replay with two freed entries pending.
    free_ready = 1'b0;
    commit(9, 40, 1);
    commit(10, 41, 1);
    check_free("t6_two");
`ifdef COMMIT_MAP_STATS_EN
    check("stat_commits", stat_commits, exp_commits);
    check("stat_frees", stat_frees, exp_frees);
`endif
    hc.flush = 1'b1;
    tick();
    hc.flush = 1'b0;
    tick();
    check("t6_mid_restore", restore_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check("t6_commit_ready", commit_ready, 0);
    check("t6_free_valid", free_valid, 0);
    check("t6_free_preg", free_preg, 0);
    check("t6_restore_valid", restore_valid, 0);
    check("t6_restore_logical", restore_logical, 0);
    check("t6_restore_physical", restore_physical, 0);
    check("t6_restore_busy", restore_busy, 0);
`ifdef COMMIT_MAP_STATS_EN
    check("t6_stat_commits", stat_commits, 0);
    check("t6_stat_frees", stat_frees, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_free("t6_after_release");
    replay(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
